// File: rtl/draw_score_pkg.sv
// draw_score_pkg: shared glyph table, cell geometry and pixel-bundle types
package draw_score_pkg;
  localparam int CNT_W = 11;
  localparam int DIGIT_W = 5;
  localparam int DIGIT_H = 7;
  localparam int CELL_W = 6;
  typedef logic [11:0] rgb_t;
  typedef struct packed {
    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic hs;
    logic vs;
    logic hb;
    logic vb;
  } timing_t;
  localparam logic [DIGIT_W-1:0] FONT [10][DIGIT_H] = '{
    '{5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E},
    '{5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},
    '{5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F},
    '{5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E},
    '{5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02},
    '{5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E},
    '{5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E},
    '{5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08},
    '{5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E},
    '{5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C}
  };
endpackage

// File: rtl/digit_font_5x7.sv
// digit_font_5x7: row bitmap of a decimal glyph, bit 4 is the leftmost dot
module digit_font_5x7 import draw_score_pkg::*; (
  input  logic [3:0]         digit,
  input  logic [2:0]         row,
  output logic [DIGIT_W-1:0] bits
);
  // non-decimal digits and rows below the glyph are blank
  always_comb bits = (digit > 4'd9 || row > 3'd6) ? '0 : FONT[digit][row];
endmodule

// File: rtl/draw_score.sv
// draw_score: two-digit score overlay, frame-latched score, 2-cycle pipeline
module draw_score import draw_score_pkg::*; #(
  parameter int         X_POS      = 16,
  parameter int         Y_POS      = 8,
  parameter int         SCALE_LOG2 = 2,
  parameter logic [11:0] COLOR     = 12'hFF0,
  parameter int         SCORE_W    = 4
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [10:0]        hcount_in,
  input  logic [10:0]        vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               hblnk_in,
  input  logic               vblnk_in,
  input  logic [11:0]        rgb_in,
  input  logic [SCORE_W-1:0] score,
  input  logic               show,
  output logic [10:0]        hcount_out,
  output logic [10:0]        vcount_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               hblnk_out,
  output logic               vblnk_out,
  output logic [11:0]        rgb_out
);
  localparam logic [CNT_W:0] X_LO = (CNT_W+1)'(X_POS);
  localparam logic [CNT_W:0] X_HI = (CNT_W+1)'(X_POS + ((2*CELL_W) << SCALE_LOG2));
  localparam logic [CNT_W:0] Y_LO = (CNT_W+1)'(Y_POS);
  localparam logic [CNT_W:0] Y_HI = (CNT_W+1)'(Y_POS + (DIGIT_H << SCALE_LOG2));

  logic [SCORE_W-1:0] score_d, score_q;
  logic               vbl_d, vbl_q;
  logic [DIGIT_W-1:0] glyph_d, glyph_q;
  logic [2:0]         c_d, c_q;
  logic               box_d, box_q;
  rgb_t               rgb1_d, rgb1_q, rgb2_d, rgb2_q;
  timing_t            t1_d, t1_q, t2_d, t2_q;
  logic [CNT_W-1:0]   dx, dy;
  logic [3:0]         col, digit, units;
  logic [2:0]         row;
  logic               tens, right, dot;

  digit_font_5x7 u_font (.digit(digit), .row(row), .bits(glyph_d));

  // score latch on vblank start, BCD split, font lookup and both pipeline stages
  always_comb begin
    vbl_d = vblnk_in;
    score_d = (vblnk_in && !vbl_q) ? score : score_q;
    tens = score_q >= SCORE_W'(10);
    units = tens ? 4'(score_q - SCORE_W'(10)) : 4'(score_q);
    dx = hcount_in - CNT_W'(X_POS);
    dy = vcount_in - CNT_W'(Y_POS);
    col = 4'(dx >> SCALE_LOG2);
    row = 3'(dy >> SCALE_LOG2);
    right = col >= 4'(CELL_W);
    digit = right ? units : {3'b0, tens};
    c_d = right ? 3'(col - 4'(CELL_W)) : col[2:0];
    box_d = {1'b0, hcount_in} >= X_LO && {1'b0, hcount_in} < X_HI &&
            {1'b0, vcount_in} >= Y_LO && {1'b0, vcount_in} < Y_HI;
    rgb1_d = rgb_in;
    t1_d = '{hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
    dot = c_q <= 3'd4 && glyph_q[3'd4 - c_q];
    t2_d = t1_q;
    rgb2_d = (show && box_q && dot && !t1_q.hb && !t1_q.vb) ? COLOR : rgb1_q;
  end

  // state registers, cleared asynchronously
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      score_q <= '0;
      vbl_q <= 1'b0;
      glyph_q <= '0;
      c_q <= '0;
      box_q <= 1'b0;
      rgb1_q <= '0;
      rgb2_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
    end else begin
      score_q <= score_d;
      vbl_q <= vbl_d;
      glyph_q <= glyph_d;
      c_q <= c_d;
      box_q <= box_d;
      rgb1_q <= rgb1_d;
      rgb2_q <= rgb2_d;
      t1_q <= t1_d;
      t2_q <= t2_d;
    end
  end

  assign hcount_out = t2_q.hc;
  assign vcount_out = t2_q.vc;
  assign hsync_out = t2_q.hs;
  assign vsync_out = t2_q.vs;
  assign hblnk_out = t2_q.hb;
  assign vblnk_out = t2_q.vb;
  assign rgb_out = rgb2_q;
endmodule

// File: tb/tb_draw_score.sv
// tb_draw_score: random mini-raster and directed pixels against a frame-level model
module tb_draw_score;
  localparam int X = 16, Y = 8, COL = 12'hFF0;

  logic pclk = 0, rst = 1;
  logic [10:0] hc_i = 0, vc_i = 0;
  logic hs_i = 0, vs_i = 0, hb_i = 0, vb_i = 0, show = 0;
  logic [11:0] rgb_i = 0;
  logic [3:0] score = 0;
  logic [10:0] hcount_out, vcount_out;
  logic hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_score dut (
    .pclk(pclk), .rst(rst), .hcount_in(hc_i), .vcount_in(vc_i),
    .hsync_in(hs_i), .vsync_in(vs_i), .hblnk_in(hb_i), .vblnk_in(vb_i),
    .rgb_in(rgb_i), .score(score), .show(show),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  typedef struct {int hc; int vc; bit hs; bit vs; bit hb; bit vb; int rgb; bit sh; int sc; int want;} rec_t;
  rec_t h[$];
  int total = 0, bad = 0, sc_m = 0, sc_in = 0;
  bit vb_prev = 0;

  logic [4:0] font [10][7] = '{
    '{5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E},
    '{5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},
    '{5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F},
    '{5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E},
    '{5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02},
    '{5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E},
    '{5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E},
    '{5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08},
    '{5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E},
    '{5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C}
  };

  task automatic check(string tag, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_rgb(rec_t r, bit sh);
    int c, row, d;
    if (!sh || r.hb || r.vb || r.hc < X || r.hc >= X + 48 || r.vc < Y || r.vc >= Y + 28) return r.rgb;
    c = (r.hc - X) / 4;
    row = (r.vc - Y) / 4;
    d = (c < 6) ? r.sc / 10 : r.sc % 10;
    c = c % 6;
    if (c < 5 && font[d][row][4-c]) return COL;
    return r.rgb;
  endfunction

  task automatic drive(int hc, int vc, bit hs, bit vs, bit hb, bit vb, int rgb, int sc, bit sh, int want);
    rec_t r;
    hc_i = 11'(hc); vc_i = 11'(vc); hs_i = hs; vs_i = vs; hb_i = hb; vb_i = vb;
    rgb_i = 12'(rgb); score = 4'(sc); show = sh;
    r = '{hc, vc, hs, vs, hb, vb, rgb, sh, sc_m, want};
    if (vb && !vb_prev) sc_m = sc;
    vb_prev = vb;
    h.push_back(r);
  endtask

  task automatic cyc(int hc, int vc, bit hs, bit vs, bit hb, bit vb, int rgb, int sc, bit sh, int want);
    rec_t o;
    @(negedge pclk);
    o = h.pop_front();
    check("hcount", hcount_out, o.hc);
    check("vcount", vcount_out, o.vc);
    check("hsync", hsync_out, o.hs);
    check("vsync", vsync_out, o.vs);
    check("hblnk", hblnk_out, o.hb);
    check("vblnk", vblnk_out, o.vb);
    check($sformatf("rgb@%0d,%0d", o.hc, o.vc), rgb_out, ref_rgb(o, h[0].sh));
    if (o.want >= 0) check($sformatf("pix@%0d,%0d", o.hc, o.vc), rgb_out, o.want);
    drive(hc, vc, hs, vs, hb, vb, rgb, sc, sh, want);
  endtask

  task automatic chk_zero(string tag);
    check({tag, "_hc"}, hcount_out, 0);
    check({tag, "_vc"}, vcount_out, 0);
    check({tag, "_tim"}, {hsync_out, vsync_out, hblnk_out, vblnk_out}, 0);
    check({tag, "_rgb"}, rgb_out, 0);
  endtask

  task automatic do_reset();
    rec_t z = '{default: 0};
    z.want = -1;
    @(negedge pclk);
    #2 rst = 0;
    #1 chk_zero("rst");
    @(negedge pclk);
    chk_zero("rst_hold");
    rst = 1;
    h.delete();
    h.push_back(z);
    sc_m = 0;
    vb_prev = 0;
    drive(0, 0, 0, 0, 0, 0, 0, sc_in, 1, -1);
  endtask

  task automatic latch(int s);
    sc_in = s;
    cyc(0, 0, 0, 0, 0, 0, 0, s, 1, -1);
    cyc(0, 0, 0, 0, 0, 1, 0, s, 1, -1);
    cyc(0, 0, 0, 0, 0, 0, 0, s, 1, -1);
  endtask

  initial begin
    #1 rst = 0;
    do_reset();
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 1, -1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, -1);
    latch(7);
    cyc(16, 8, 0, 0, 0, 0, 12'h0A0, 7, 1, 12'h0A0);
    cyc(20, 8, 0, 0, 0, 0, 12'h0A0, 7, 1, COL);
    cyc(20, 8, 0, 0, 1, 0, 12'h0A0, 7, 1, 12'h0A0);
    cyc(20, 8, 0, 0, 0, 1, 12'h0A0, 7, 1, 12'h0A0);
    cyc(20, 8, 0, 0, 0, 0, 12'h0A0, 7, 1, 12'h0A0);
    cyc(0, 0, 0, 0, 0, 0, 0, 7, 0, -1);
    cyc(20, 8, 0, 0, 0, 0, 12'h0A0, 7, 1, COL);
    latch(12);
    cyc(48, 32, 0, 0, 0, 0, 12'h123, 12, 1, COL);
    cyc(36, 8, 0, 0, 0, 0, 12'h456, 12, 1, 12'h456);
    cyc(64, 8, 0, 0, 0, 0, 12'h789, 12, 1, 12'h789);
    cyc(63, 34, 0, 0, 0, 0, 12'hABC, 12, 1, 12'hABC);
    latch(3);
    sc_in = 4;
    cyc(0, 300, 0, 0, 0, 0, 0, 4, 1, -1);
    cyc(40, 8, 0, 0, 0, 0, 12'h0A0, 4, 1, COL);
    latch(4);
    cyc(40, 8, 0, 0, 0, 0, 12'h0A0, 4, 1, 12'h0A0);
    for (int f = 0; f < 5; f++)
      for (int vc = 0; vc < 44; vc++)
        for (int hc = 0; hc < 80; hc++) begin
          if (f == 2 && vc == 10 && hc == 30) do_reset();
          if ($urandom_range(499) == 0) sc_in = $urandom_range(15);
          cyc(hc, vc, hc >= 74 && hc < 77, vc == 41, hc >= 72, vc >= 40,
              $urandom_range(4095), sc_in, $urandom_range(7) != 0, -1);
        end
    cyc(0, 0, 0, 0, 0, 0, 0, sc_in, 1, -1);
    cyc(0, 0, 0, 0, 0, 0, 0, sc_in, 1, -1);
    cyc(0, 0, 0, 0, 0, 0, 0, sc_in, 1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
